axis_hdr_insert_v2: RTL and testbench
=====================================

Name: axis_hdr_insert_v2

Overview:
- Parametrised successor of the single-beat AXI-Stream header inserter.
- Prepends 0..DATA_BYTE_WD header bytes to every packet and repacks payload bytes across beats.
- Emits an extra tail beat when the bytes spill over, and handles full ready/valid backpressure on all three interfaces.
- Sits between a packet source and the framing/egress logic.
- Byte order is MSB-first: byte DATA_BYTE_WD-1 leaves first; keep is MSB-aligned and contiguous.

Parameters:
- DATA_WD, 32, stream width in bits; multiple of 8, 8..512.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- CNT_WD, $clog2(DATA_BYTE_WD)+1, width of the byte counts (holds 0..DATA_BYTE_WD).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low, on clock clk.
- valid_in  in  1  payload valid.
- data_in  in  DATA_WD  payload data.
- keep_in  in  DATA_BYTE_WD  payload byte enables; MSB-aligned, contiguous; all ones except on the last beat.
- last_in  in  1  last payload beat.
- ready_in  out  1  payload ready.
- valid_out  out  1  output valid (registered).
- data_out  out  DATA_WD  output data (registered).
- keep_out  out  DATA_BYTE_WD  output byte enables (registered).
- last_out  out  1  output last (registered).
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header; the valid bytes are the low n bytes.
- byte_insert_cnt  in  CNT_WD  header byte count n; values > DATA_BYTE_WD saturate to DATA_BYTE_WD.
- ready_insert  out  1  header ready.

Behaviour:
- Reset:
  - valid_out=0, data_out=0, keep_out=0, last_out=0.
  - state=IDLE, residual and n cleared.
  - ready_in=0 and ready_insert=0 while rst_n=0.
- Advance signal: adv = ~valid_out | ready_out. The output register loads only when adv=1. With ready_out=0, all outputs hold stable.
- Notation: W = DATA_BYTE_WD; k = popcount(keep_in).
- State IDLE:
  - ready_insert = adv; ready_in = 0.
  - On header handshake: latch n = byte_insert_cnt; residual = low n bytes of data_insert; go to STREAM.
  - Header handshake produces no output beat.
- State STREAM:
  - ready_in = adv; ready_insert = 0.
  - Per payload handshake:
    - data_out = {residual (n bytes), top W-n bytes of data_in}.
    - keep_out = same merge of the residual keep and keep_in.
    - residual <= low n bytes of data_in.
  - If last_in and k+n <= W: last_out=1; go to IDLE.
  - If last_in and k+n > W: last_out=0; go to TAIL.
- State TAIL:
  - ready_in=0; ready_insert=0.
  - When adv: emit data_out = {residual, zeros}, keep_out = top (k+n-W) bits set, last_out=1; go to IDLE.
- n=0: pure passthrough; no tail beat is ever generated.
- n=W: first output beat is the full header; every packet gets a tail beat.
- Shift amounts of 0 and DATA_WD must yield 0 or identity (no out-of-range shifts).
- Latency:
  - First output beat appears 1 cycle after the first payload handshake.
  - One bubble cycle per packet for the header handshake.
  - Steady-state throughput is 1 beat/cycle.
- valid_out drops to 0 on an adv cycle with no handshake. data_out, keep_out and last_out hold their last values while valid_out=0.
- Simultaneous valid_insert and valid_in in IDLE: only the header is accepted.
- Header arriving mid-packet: held off by ready_insert=0 until the state returns to IDLE.
- Reset mid-packet: the packet is dropped, outputs clear, and no partial tail is emitted.
- Non-contiguous keep_in, or keep_in != all-ones on a non-last beat: output undefined; not checked.

Decomposition:
- Package axis_hdr_pkg:
  - state enum {IDLE, STREAM, TAIL}.
  - function keep_popcount(keep).
  - function keep_from_cnt(cnt) returning an MSB-aligned mask.
  - function sat_cnt(cnt, W).
- Sub-module axis_hdr_merge (combinational):
  - Inputs: residual data/keep, data_in/keep_in, n.
  - Outputs: merged data/keep, next residual, overflow flag (k+n>W), tail keep.
- The top level holds the FSM and the output register.

Test Plan:
- W=4, n=2, hdr=0x0000AABB; payload 0x11223344/1111, 0x55667788/1111 last -> beats 0xAABB1122/1111, 0x33445566/1111, tail 0x77880000/1100 last.
- W=4, n=1, hdr=0x000000CC; single beat 0x11223300/1110 last -> 0xCC112233/1111 last; no tail; state returns to IDLE.
- n=0 -> output equals input beat-for-beat. n=4, hdr=0xDEADBEEF, 1 beat 0x12345678/1111 -> 0xDEADBEEF/1111, then 0x12345678/1111 last.
- Random ready_out stalls (50%) across 100 packets with random n and k -> scoreboard byte stream matches; outputs stable while stalled; no drop or duplication.
- Header offered during STREAM/TAIL -> ready_insert=0 until IDLE. Back-to-back packets -> exactly one bubble each.
- Assert rst_n=0 mid-packet (n=3) -> next cycle valid_out=0; a following fresh packet is correct with no stale residual bytes.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
// Contents:
//   state_e        - inserter FSM states
//   keep_popcount  - number of set bits in a keep vector (up to MaxBytes lanes)
//   keep_from_cnt  - MSB-aligned keep mask of cnt set bits within a w-lane vector
//   sat_cnt        - clamp a byte count to w
package axis_hdr_pkg;

  localparam int unsigned MaxBytes = 64;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StTail
  } state_e;

  function automatic int unsigned keep_popcount(input logic [MaxBytes-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      cnt += 32'(keep[i]);
    end
    return cnt;
  endfunction

  function automatic logic [MaxBytes-1:0] keep_from_cnt(input int unsigned cnt,
                                                        input int unsigned w);
    logic [MaxBytes-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      if ((i < w) && (i + cnt >= w)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  function automatic int unsigned sat_cnt(input int unsigned cnt, input int unsigned w);
    return (cnt > w) ? w : cnt;
  endfunction

endpackage

// File: rtl/axis_hdr_merge.sv
// Combinational byte-repacking datapath for the header inserter.
// Ports:
//   res_data/res_keep          - carried-over bytes, right-aligned (low n lanes)
//   data_in/keep_in            - current payload beat
//   n                          - carried byte count, already clamped to DATA_BYTE_WD
//   merged_data/merged_keep    - {residual, top W-n payload bytes}
//   next_res_data/next_res_keep- low n payload bytes, to carry into the next beat
//   overflow                   - popcount(keep_in) + n exceeds one beat
//   tail_data/tail_keep        - flush beat built from the residual alone
module axis_hdr_merge
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      res_data,
  input  logic [DATA_BYTE_WD-1:0] res_keep,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic [CNT_WD-1:0]       n,
  output logic [DATA_WD-1:0]      merged_data,
  output logic [DATA_BYTE_WD-1:0] merged_keep,
  output logic [DATA_WD-1:0]      next_res_data,
  output logic [DATA_BYTE_WD-1:0] next_res_keep,
  output logic                    overflow,
  output logic [DATA_WD-1:0]      tail_data,
  output logic [DATA_BYTE_WD-1:0] tail_keep
);

  localparam int unsigned W = DATA_BYTE_WD;

  int unsigned n_int;

  // Lane-wise selection instead of shifts so n=0 and n=W never need an
  // out-of-range shift amount.
  always_comb begin
    n_int         = 32'(n);
    merged_data   = '0;
    merged_keep   = '0;
    next_res_data = '0;
    next_res_keep = '0;
    tail_data     = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i + n_int >= W) begin
        merged_data[8*i +: 8] = res_data[8*(i+n_int-W) +: 8];
        merged_keep[i]        = res_keep[i+n_int-W];
        tail_data[8*i +: 8]   = res_data[8*(i+n_int-W) +: 8];
      end else begin
        merged_data[8*i +: 8] = data_in[8*(i+n_int) +: 8];
        merged_keep[i]        = keep_in[i+n_int];
      end
      if (i < n_int) begin
        next_res_data[8*i +: 8] = data_in[8*i +: 8];
        next_res_keep[i]        = keep_in[i];
      end
    end
    overflow  = (keep_popcount(MaxBytes'(keep_in)) + n_int) > W;
    // In the tail state the residual holds exactly the k+n-W spilled bytes.
    tail_keep = DATA_BYTE_WD'(keep_from_cnt(keep_popcount(MaxBytes'(res_keep)), W));
  end

endmodule

// File: rtl/axis_hdr_insert_v2.sv
// AXI-Stream header inserter: prepends 0..DATA_BYTE_WD header bytes to each packet,
// repacking the payload MSB-first and adding a tail beat when bytes spill over.
// Ports:
//   clk, rst_n                                  - clock, synchronous active-low reset
//   valid_in/data_in/keep_in/last_in/ready_in   - payload stream (sink)
//   valid_out/data_out/keep_out/last_out/ready_out - output stream (source, registered)
//   valid_insert/data_insert/byte_insert_cnt/ready_insert - header (low n bytes valid)
module axis_hdr_insert_v2
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [CNT_WD-1:0]       byte_insert_cnt,
  output logic                    ready_insert
);

  state_e                  state_q, state_d;
  logic [CNT_WD-1:0]       n_q, n_d;
  logic [DATA_WD-1:0]      res_data_q, res_data_d;
  logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
  logic                    valid_q, valid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;

  logic [DATA_WD-1:0]      merged_data, next_res_data, tail_data;
  logic [DATA_BYTE_WD-1:0] merged_keep, next_res_keep, tail_keep;
  logic                    overflow;
  logic                    adv;
  int unsigned             n_sat;

  axis_hdr_merge #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .CNT_WD      (CNT_WD)
  ) u_merge (
    .res_data     (res_data_q),
    .res_keep     (res_keep_q),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .n            (n_q),
    .merged_data  (merged_data),
    .merged_keep  (merged_keep),
    .next_res_data(next_res_data),
    .next_res_keep(next_res_keep),
    .overflow     (overflow),
    .tail_data    (tail_data),
    .tail_keep    (tail_keep)
  );

  assign adv   = ~valid_q | ready_out;
  assign n_sat = sat_cnt(32'(byte_insert_cnt), DATA_BYTE_WD);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    res_data_d   = res_data_q;
    res_keep_d   = res_keep_q;
    valid_d      = valid_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_insert = adv & rst_n;
        if (adv) valid_d = 1'b0;
        if (valid_insert && ready_insert) begin
          n_d = CNT_WD'(n_sat);
          for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            res_data_d[8*i +: 8] = (i < n_sat) ? data_insert[8*i +: 8] : 8'h00;
            res_keep_d[i]        = (i < n_sat);
          end
          state_d = StStream;
        end
      end
      StStream: begin
        ready_in = adv & rst_n;
        if (adv) begin
          valid_d = valid_in;
          if (valid_in) begin
            data_d     = merged_data;
            keep_d     = merged_keep;
            last_d     = last_in & ~overflow;
            res_data_d = next_res_data;
            res_keep_d = next_res_keep;
            if (last_in) state_d = overflow ? StTail : StIdle;
          end
        end
      end
      StTail: begin
        if (adv) begin
          valid_d = 1'b1;
          data_d  = tail_data;
          keep_d  = tail_keep;
          last_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      res_data_q <= '0;
      res_keep_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      res_data_q <= res_data_d;
      res_keep_q <= res_keep_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_axis_hdr_insert_v2.sv
// Self-checking bench for axis_hdr_insert_v2 (W=4): directed packets with
// hand-computed beats, a randomised stall run checked as a byte stream, and a
// mid-packet reset.
module tb_axis_hdr_insert_v2;

  localparam int unsigned DATA_WD = 32;
  localparam int unsigned W       = DATA_WD / 8;
  localparam int unsigned CNT_WD  = $clog2(W) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in, last_in, ready_in;
  logic [DATA_WD-1:0] data_in;
  logic [W-1:0]      keep_in;
  logic              valid_out, last_out, ready_out;
  logic [DATA_WD-1:0] data_out;
  logic [W-1:0]      keep_out;
  logic              valid_insert, ready_insert;
  logic [DATA_WD-1:0] data_insert;
  logic [CNT_WD-1:0] byte_insert_cnt;

  always #5 clk = ~clk;

  axis_hdr_insert_v2 #(.DATA_WD(DATA_WD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_insert   (valid_insert),
    .data_insert    (data_insert),
    .byte_insert_cnt(byte_insert_cnt),
    .ready_insert   (ready_insert)
  );

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic [W-1:0]       keep;
    logic               last;
  } beat_t;

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic [CNT_WD-1:0]  cnt;
  } hdr_t;

  hdr_t        hdr_q[$];
  beat_t       pay_q[$];
  beat_t       out_q[$];
  int          out_cyc[$];
  logic [7:0]  exp_bytes[$];
  int unsigned exp_len[$];
  beat_t       exp_dir[12];

  int          hi, pi, cyc, first_pay_cyc;
  int          n_tests, n_fail;
  bit          in_pkt, tail_pend, stalled;
  beat_t       held;
  int unsigned cur_n, stall_pct, gap_pct;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ones(input logic [W-1:0] k);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(W); i++) if (k[i]) c++;
    return c;
  endfunction

  task automatic add_hdr(input logic [DATA_WD-1:0] d, input int unsigned cnt);
    hdr_q.push_back({d, CNT_WD'(cnt)});
  endtask

  task automatic add_beat(input logic [DATA_WD-1:0] d, input logic [W-1:0] k, input logic l);
    pay_q.push_back({d, k, l});
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic cycle_io(input bit force_ready);
    bit adv;
    @(negedge clk);
    ready_out       = force_ready || ($urandom_range(99) >= stall_pct);
    valid_insert    = 1'b0;
    data_insert     = '0;
    byte_insert_cnt = '0;
    if (hi < hdr_q.size() && $urandom_range(99) >= gap_pct) begin
      valid_insert    = 1'b1;
      data_insert     = hdr_q[hi].data;
      byte_insert_cnt = hdr_q[hi].cnt;
    end
    valid_in = 1'b0;
    data_in  = '0;
    keep_in  = '0;
    last_in  = 1'b0;
    if (pi < pay_q.size() && $urandom_range(99) >= gap_pct) begin
      valid_in = 1'b1;
      data_in  = pay_q[pi].data;
      keep_in  = pay_q[pi].keep;
      last_in  = pay_q[pi].last;
    end
    #1;
    if (stalled)
      check_eq("stall_hold", 64'({valid_out, data_out, keep_out, last_out}), 64'({1'b1, held}));
    if (in_pkt || tail_pend) check_eq("hdr_holdoff", 64'(ready_insert), 64'(0));
    if (!in_pkt) check_eq("pay_holdoff", 64'(ready_in), 64'(0));
    adv = !valid_out || ready_out;
    if (valid_out && ready_out) begin
      out_q.push_back({data_out, keep_out, last_out});
      out_cyc.push_back(cyc);
    end
    stalled = valid_out && !ready_out;
    held    = {data_out, keep_out, last_out};
    if (tail_pend && adv) tail_pend = 1'b0;
    if (valid_insert && ready_insert) begin
      in_pkt = 1'b1;
      cur_n  = (32'(byte_insert_cnt) > W) ? W : 32'(byte_insert_cnt);
      hi++;
    end
    if (valid_in && ready_in) begin
      if (first_pay_cyc < 0) first_pay_cyc = cyc;
      if (last_in) begin
        in_pkt    = 1'b0;
        tail_pend = (ones(keep_in) + cur_n) > W;
      end
      pi++;
    end
    cyc++;
  endtask

  task automatic run(input int unsigned stall, input int unsigned gap);
    int budget;
    stall_pct     = stall;
    gap_pct       = gap;
    hi            = 0;
    pi            = 0;
    budget        = 0;
    first_pay_cyc = -1;
    out_q.delete();
    out_cyc.delete();
    while ((hi < hdr_q.size() || pi < pay_q.size()) && budget < 20000) begin
      cycle_io(1'b0);
      budget++;
    end
    check_eq("feed_hdr", 64'(hi), 64'(hdr_q.size()));
    check_eq("feed_pay", 64'(pi), 64'(pay_q.size()));
    repeat (8) cycle_io(1'b1);
  endtask

  initial begin
    int unsigned n_raw, n, nb, k, pos, blen, bbeats;
    logic [DATA_WD-1:0] d;
    logic [W-1:0] kp;
    logic [7:0] got_bytes[$];
    int unsigned got_len[$], got_beats[$];
    int guard;

    n_tests = 0; n_fail = 0; cyc = 0;
    in_pkt = 1'b0; tail_pend = 1'b0; stalled = 1'b0; cur_n = 0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; ready_out = 1'b0;
    valid_insert = 1'b0; data_insert = '0; byte_insert_cnt = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_outs", 64'({valid_out, data_out, keep_out, last_out}), 64'(0));
    check_eq("rst_readies", 64'({ready_in, ready_insert}), 64'(0));
    rst_n = 1'b1;

    // Directed packets, back to back, no stalls.
    add_hdr(32'h0000AABB, 2); add_beat(32'h11223344, 4'hF, 1'b0);
    add_beat(32'h55667788, 4'hF, 1'b1);
    add_hdr(32'h000000CC, 1); add_beat(32'h11223300, 4'hE, 1'b1);
    add_hdr(32'h99999999, 0); add_beat(32'h01020304, 4'hF, 1'b0);
    add_beat(32'hA0B0C000, 4'hE, 1'b1);
    add_hdr(32'hDEADBEEF, 4); add_beat(32'h12345678, 4'hF, 1'b1);
    add_hdr(32'hCAFEF00D, 7); add_beat(32'h0A000000, 4'h8, 1'b1);
    add_hdr(32'h00112233, 3); add_beat(32'h44000000, 4'h8, 1'b1);
    exp_dir[0]  = {32'hAABB1122, 4'hF, 1'b0};
    exp_dir[1]  = {32'h33445566, 4'hF, 1'b0};
    exp_dir[2]  = {32'h77880000, 4'hC, 1'b1};
    exp_dir[3]  = {32'hCC112233, 4'hF, 1'b1};
    exp_dir[4]  = {32'h01020304, 4'hF, 1'b0};
    exp_dir[5]  = {32'hA0B0C000, 4'hE, 1'b1};
    exp_dir[6]  = {32'hDEADBEEF, 4'hF, 1'b0};
    exp_dir[7]  = {32'h12345678, 4'hF, 1'b1};
    exp_dir[8]  = {32'hCAFEF00D, 4'hF, 1'b0};
    exp_dir[9]  = {32'h0A000000, 4'h8, 1'b1};
    exp_dir[10] = {32'h11223344, 4'hF, 1'b1};
    exp_dir[11] = {32'h11223344, 4'hF, 1'b1};
    run(0, 0);
    check_eq("dir_count", 64'(out_q.size()), 64'(11));
    for (int i = 0; i < 11 && i < out_q.size(); i++) begin
      check_eq($sformatf("dir_beat%0d", i), 64'(out_q[i]), 64'(exp_dir[i]));
      // One bubble between packets, none within a packet.
      if (i > 0)
        check_eq($sformatf("dir_gap%0d", i), 64'(out_cyc[i] - out_cyc[i-1]),
                 exp_dir[i-1].last ? 64'(2) : 64'(1));
    end
    if (out_q.size() > 0)
      check_eq("first_latency", 64'(out_cyc[0] - first_pay_cyc), 64'(1));

    // Random n/k with 50% output stalls, checked as a per-packet byte stream.
    hdr_q.delete(); pay_q.delete(); exp_bytes.delete(); exp_len.delete();
    for (int p = 0; p < 100; p++) begin
      n_raw = $urandom_range(7);
      n     = (n_raw > W) ? W : n_raw;
      d     = $urandom();
      add_hdr(d, n_raw);
      for (int b = int'(n) - 1; b >= 0; b--) exp_bytes.push_back(d[8*b +: 8]);
      nb = $urandom_range(1, 4);
      for (int j = 0; j < int'(nb); j++) begin
        k  = (j == int'(nb) - 1) ? $urandom_range(1, W) : W;
        kp = '0;
        for (int i = 0; i < int'(k); i++) kp[W-1-i] = 1'b1;
        d = $urandom();
        add_beat(d, kp, j == int'(nb) - 1);
        for (int i = 0; i < int'(k); i++) exp_bytes.push_back(d[8*(W-1-i) +: 8]);
        if (j == int'(nb) - 1) exp_len.push_back(n + W * (nb - 1) + k);
      end
    end
    run(50, 25);
    blen = 0; bbeats = 0;
    foreach (out_q[i]) begin
      for (int b = int'(W) - 1; b >= 0; b--)
        if (out_q[i].keep[b]) begin
          got_bytes.push_back(out_q[i].data[8*b +: 8]);
          blen++;
        end
      bbeats++;
      if (out_q[i].last) begin
        got_len.push_back(blen);
        got_beats.push_back(bbeats);
        blen = 0; bbeats = 0;
      end
    end
    check_eq("rnd_pkts", 64'(got_len.size()), 64'(exp_len.size()));
    check_eq("rnd_bytes", 64'(got_bytes.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < got_len.size() && i < exp_len.size(); i++) begin
      check_eq($sformatf("rnd_len%0d", i), 64'(got_len[i]), 64'(exp_len[i]));
      check_eq($sformatf("rnd_beats%0d", i), 64'(got_beats[i]), 64'((exp_len[i] + W - 1) / W));
    end
    pos = 0;
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      check_eq($sformatf("rnd_byte%0d", i), 64'(got_bytes[i]), 64'(exp_bytes[i]));
      pos++;
    end

    // Reset in the middle of an n=3 packet.
    hdr_q.delete(); pay_q.delete(); out_q.delete(); out_cyc.delete();
    add_hdr(32'h00C0C1C2, 3);
    add_beat(32'h01020304, 4'hF, 1'b0);
    add_beat(32'h05060708, 4'hF, 1'b0);
    add_beat(32'h090A0B0C, 4'hF, 1'b1);
    stall_pct = 0; gap_pct = 0; hi = 0; pi = 0; guard = 0;
    while (pi < 2 && guard < 50) begin
      cycle_io(1'b1);
      guard++;
    end
    check_eq("rst_pre_feed", 64'(pi), 64'(2));
    @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b0; valid_insert = 1'b0;
    #1;
    check_eq("rst_mid_readies", 64'({ready_in, ready_insert}), 64'(0));
    @(negedge clk);
    #1;
    check_eq("rst_mid_outs", 64'({valid_out, data_out, keep_out, last_out}), 64'(0));
    rst_n = 1'b1;
    in_pkt = 1'b0; tail_pend = 1'b0; stalled = 1'b0;
    hdr_q.delete(); pay_q.delete();
    add_hdr(32'h00A1A2A3, 3); add_beat(32'h11223344, 4'hF, 1'b1);
    run(0, 0);
    check_eq("post_rst_count", 64'(out_q.size()), 64'(2));
    if (out_q.size() > 0)
      check_eq("post_rst_beat0", 64'(out_q[0]), 64'({32'hA1A2A311, 4'hF, 1'b0}));
    if (out_q.size() > 1)
      check_eq("post_rst_beat1", 64'(out_q[1]), 64'({32'h22334400, 4'hE, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
